// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader and owner of the instruction RAM
// write port. Watches a framed UART byte stream (SYNC_BYTE, word count N,
// then 4*N data bytes), packs bytes little-endian into 32-bit words and
// writes them sequentially from word 0. The processor is held in reset for
// the whole load and released once load_en drops.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   load_en          level request for load mode
//   rx_valid/rx_data one-cycle byte strobe and byte from the UART receiver
//   mem_we/wa/wd     instruction RAM write port (one pulse per word)
//   cpu_reset        processor reset request
//   busy             frame reception in progress
//   done             complete frame written
//   err              sticky: last load timed out or was aborted
//   words_loaded     words written in the current frame
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_RUN      | processor running, byte stream ignored
// S_WAIT_SYNC| load mode, discarding bytes until SYNC_BYTE
// S_COUNT    | next byte is the word count N (0 => 2^ADDR_W)
// S_DATA     | packing data bytes and writing words
// S_DONE     | frame complete, waiting for load_en to drop
module imem_loader #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [31:0]       mem_wd,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Idle timer counts down from TIMEOUT-1; an idle edge seen at zero is
    // the TIMEOUT-th idle cycle since the last accepted byte.
    localparam logic [TW-1:0]   IDLE_LOAD = TW'(TIMEOUT - 1);
    localparam logic [ADDR_W:0] FULL      = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {S_RUN, S_WAIT_SYNC, S_COUNT, S_DATA, S_DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W:0]   target, target_n;
    logic [1:0]        bidx, bidx_n;
    logic [23:0]       wbuf, wbuf_n;
    logic [TW-1:0]     idle, idle_n;
    logic              mem_we_n, cpu_reset_n, busy_n, done_n, err_n;
    logic [ADDR_W-1:0] mem_wa_n;
    logic [31:0]       mem_wd_n;
    logic [ADDR_W:0]   words_n, words_inc;

    assign words_inc = words_loaded + 1'b1;

    always_comb begin
        state_n     = state;
        target_n    = target;
        bidx_n      = bidx;
        wbuf_n      = wbuf;
        idle_n      = idle;
        mem_we_n    = 1'b0;
        mem_wa_n    = mem_wa;
        mem_wd_n    = mem_wd;
        cpu_reset_n = cpu_reset;
        done_n      = done;
        err_n       = err;
        words_n     = words_loaded;

        case (state)
            S_RUN: begin
                cpu_reset_n = 1'b0;
                if (load_en) begin
                    state_n     = S_WAIT_SYNC;
                    cpu_reset_n = 1'b1;
                    err_n       = 1'b0;
                    done_n      = 1'b0;
                end
            end
            S_WAIT_SYNC: begin
                if (!load_en) begin
                    state_n     = S_RUN;
                    cpu_reset_n = 1'b0;
                end else if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_n = S_COUNT;
                    idle_n  = IDLE_LOAD;
                end
            end
            S_COUNT: begin
                if (!load_en) begin
                    state_n     = S_RUN;
                    cpu_reset_n = 1'b0;
                    err_n       = 1'b1;
                end else if (rx_valid) begin
                    target_n = (rx_data == 8'd0) ? FULL : (ADDR_W + 1)'(rx_data);
                    words_n  = '0;
                    bidx_n   = 2'd0;
                    idle_n   = IDLE_LOAD;
                    state_n  = S_DATA;
                end else if (idle == '0) begin
                    err_n   = 1'b1;
                    state_n = S_WAIT_SYNC;
                end else begin
                    idle_n = idle - 1'b1;
                end
            end
            S_DATA: begin
                if (!load_en) begin
                    state_n     = S_RUN;
                    cpu_reset_n = 1'b0;
                    err_n       = 1'b1;
                end else if (rx_valid) begin
                    idle_n = IDLE_LOAD;
                    bidx_n = bidx + 1'b1;
                    // Shift in from the top so b0 ends up in the low byte.
                    wbuf_n = {rx_data, wbuf[23:8]};
                    if (bidx == 2'd3) begin
                        mem_we_n = 1'b1;
                        mem_wa_n = words_loaded[ADDR_W-1:0];
                        mem_wd_n = {rx_data, wbuf};
                        words_n  = words_inc;
                        if (words_inc == target) begin
                            state_n = S_DONE;
                            done_n  = 1'b1;
                        end
                    end
                end else if (idle == '0) begin
                    err_n   = 1'b1;
                    bidx_n  = 2'd0;
                    state_n = S_WAIT_SYNC;
                end else begin
                    idle_n = idle - 1'b1;
                end
            end
            S_DONE: begin
                if (!load_en) begin
                    state_n     = S_RUN;
                    cpu_reset_n = 1'b0;
                end
            end
            default: state_n = S_RUN;
        endcase

        busy_n = (state_n == S_WAIT_SYNC) || (state_n == S_COUNT) || (state_n == S_DATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RUN;
            target       <= '0;
            bidx         <= 2'd0;
            wbuf         <= '0;
            idle         <= '0;
            mem_we       <= 1'b0;
            mem_wa       <= '0;
            mem_wd       <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_n;
            target       <= target_n;
            bidx         <= bidx_n;
            wbuf         <= wbuf_n;
            idle         <= idle_n;
            mem_we       <= mem_we_n;
            mem_wa       <= mem_wa_n;
            mem_wd       <= mem_wd_n;
            cpu_reset    <= cpu_reset_n;
            busy         <= busy_n;
            done         <= done_n;
            err          <= err_n;
            words_loaded <= words_n;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, load_en, rx_valid;
    logic [7:0]  rx_data;
    logic        mem_we, cpu_reset, busy, done, err;
    logic [7:0]  mem_wa;
    logic [31:0] mem_wd;
    logic [8:0]  words_loaded;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wq_wa[$];
    logic [31:0] wq_wd[$];
    logic [7:0]  data_q[$];

    typedef struct {
        int         njunk;
        logic [7:0] junk;
        logic [7:0] nbyte;
        int         gap;
        int         exp_words;
        int         exp_last_wa;
    } vec_t;

    vec_t vecs[5];

    imem_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .rx_valid(rx_valid),
        .rx_data(rx_data), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wq_wa.push_back(mem_wa);
            wq_wd.push_back(mem_wd);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Expected words derived directly from the byte list: word k is bytes
    // 4k..4k+3 little-endian, written at address k mod 256.
    task automatic compare_writes(input string tag, input int exp_words, input int exp_last_wa);
        logic [31:0] w;
        chk({tag, "_nwrites"}, 32'(wq_wa.size()), 32'(exp_words));
        for (int k = 0; k < exp_words && k < wq_wa.size(); k++) begin
            w = {data_q[4*k+3], data_q[4*k+2], data_q[4*k+1], data_q[4*k]};
            if (32'(wq_wa[k]) !== 32'(k % 256)) chk({tag, "_wa"}, 32'(wq_wa[k]), 32'(k % 256));
            if (wq_wd[k] !== w) chk({tag, "_wd"}, wq_wd[k], w);
        end
        if (wq_wa.size() > 0) chk({tag, "_last_wa"}, 32'(wq_wa[wq_wa.size()-1]), 32'(exp_last_wa));
    endtask

    task automatic run_frame(input string tag, input int njunk, input logic [7:0] junk,
                             input logic [7:0] nbyte, input int gap,
                             input int exp_words, input int exp_last_wa);
        wq_wa.delete();
        wq_wd.delete();
        load_en = 1'b1;
        tick();
        chk({tag, "_cpu_reset_load"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_busy_load"}, 32'(busy), 32'd1);
        for (int j = 0; j < njunk; j++) send_byte(junk, gap);
        send_byte(8'hA5, gap);
        send_byte(nbyte, gap);
        for (int j = 0; j < data_q.size(); j++) send_byte(data_q[j], gap);
        chk({tag, "_we_last"}, 32'(mem_we), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
        tick();
        chk({tag, "_we_pulse"}, 32'(mem_we), 32'd0);
        chk({tag, "_cpu_reset_held"}, 32'(cpu_reset), 32'd1);
        compare_writes(tag, exp_words, exp_last_wa);
        load_en = 1'b0;
        tick();
        chk({tag, "_cpu_release"}, 32'(cpu_reset), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        load_en  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        vecs[0] = '{1, 8'h33, 8'h02, 0,   2,   1};
        vecs[1] = '{0, 8'h00, 8'h01, 3,   1,   0};
        vecs[2] = '{2, 8'h5A, 8'h05, 1,   5,   4};
        vecs[3] = '{3, 8'hFF, 8'h03, 14,  3,   2};
        vecs[4] = '{1, 8'h12, 8'h00, 0, 256, 255};

        repeat (3) tick();
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_wa", 32'(mem_wa), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;
        tick();
        chk("run_cpu_release", 32'(cpu_reset), 32'd1 - 32'd1);

        // Bytes in RUN are ignored.
        wq_wa.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        for (int j = 0; j < 4; j++) send_byte(8'(j + 1), 0);
        tick();
        chk("run_ignore_writes", 32'(wq_wa.size()), 32'd0);
        chk("run_ignore_busy", 32'(busy), 32'd0);

        // Known program from the plan.
        data_q = '{8'h01, 8'h00, 8'hA0, 8'hE3, 8'h02, 8'h10, 8'hA0, 8'hE3};
        run_frame("plan", 1, 8'h33, 8'h02, 0, 2, 1);
        if (wq_wd.size() == 2) begin
            chk("plan_wd0", wq_wd[0], 32'hE3A00001);
            chk("plan_wd1", wq_wd[1], 32'hE3A01002);
        end else begin
            chk("plan_count", 32'(wq_wd.size()), 32'd2);
        end

        // Table of frames with random payloads.
        for (int v = 0; v < 5; v++) begin
            data_q.delete();
            for (int j = 0; j < 4 * vecs[v].exp_words; j++) data_q.push_back(8'($urandom));
            run_frame($sformatf("vec%0d", v), vecs[v].njunk, vecs[v].junk, vecs[v].nbyte,
                      vecs[v].gap, vecs[v].exp_words, vecs[v].exp_last_wa);
        end

        // Timeout after a partial word, then a fresh frame.
        wq_wa.delete();
        wq_wd.delete();
        load_en = 1'b1;
        tick();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (15) tick();
        chk("to_err_before", 32'(err), 32'd0);
        tick();
        chk("to_err", 32'(err), 32'd1);
        chk("to_busy_wait_sync", 32'(busy), 32'd1);
        chk("to_no_write", 32'(wq_wa.size()), 32'd0);
        data_q = '{8'h44, 8'h33, 8'h22, 8'h11};
        send_byte(8'h5C, 2);
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        for (int j = 0; j < 4; j++) send_byte(data_q[j], 0);
        chk("to_fresh_done", 32'(done), 32'd1);
        tick();
        compare_writes("to_fresh", 1, 0);
        load_en = 1'b0;
        tick();

        // Byte arriving on the last idle cycle wins over the timeout.
        wq_wa.delete();
        wq_wd.delete();
        data_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_en = 1'b1;
        tick();
        chk("edge_err_cleared", 32'(err), 32'd0);
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(data_q[0], 0);
        send_byte(data_q[1], 15);
        chk("edge_no_err", 32'(err), 32'd0);
        send_byte(data_q[2], 0);
        send_byte(data_q[3], 0);
        chk("edge_done", 32'(done), 32'd1);
        tick();
        compare_writes("edge", 1, 0);
        load_en = 1'b0;
        tick();

        // Abort after 6 data bytes of a 2-word frame.
        wq_wa.delete();
        wq_wd.delete();
        data_q.delete();
        for (int j = 0; j < 6; j++) data_q.push_back(8'($urandom));
        load_en = 1'b1;
        tick();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        for (int j = 0; j < 6; j++) send_byte(data_q[j], 0);
        load_en = 1'b0;
        tick();
        chk("abort_err", 32'(err), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cpu_reset", 32'(cpu_reset), 32'd0);
        compare_writes("abort", 1, 0);

        // Synchronous reset between bytes 2 and 3 of a word.
        wq_wa.delete();
        wq_wd.delete();
        load_en = 1'b1;
        tick();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        send_byte(8'h20, 0);
        reset = 1'b1;
        tick();
        chk("mrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_words", 32'(words_loaded), 32'd0);
        chk("mrst_mem_we", 32'(mem_we), 32'd0);
        reset = 1'b0;
        send_byte(8'h30, 0);
        send_byte(8'h40, 0);
        send_byte(8'h50, 0);
        send_byte(8'h60, 0);
        repeat (3) tick();
        chk("mrst_no_write", 32'(wq_wa.size()), 32'd0);
        load_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
